// File: rtl/kbd_sseg_display.sv
// Eight-digit hex view of the keyboard scancode history on an active-low,
// common-anode seven-segment display. Features: a two-stage agreement filter
// on the incoming history, time-multiplexed digit scanning, optional
// leading-zero blanking, decimal points between bytes and PWM dimming.
// All outputs are registered and lag the internal state by one clock.

module kbd_sseg_display #(
  parameter int REFRESH_CNT = 100000,
  parameter int PWM_BITS    = 4
) (
  input  logic                clk_100mhz,
  input  logic                rst,
  input  logic [31:0]         keycodes,
  input  logic                blank_zeros,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [7:0]          an
);

  localparam int                  CNT_W    = $clog2(REFRESH_CNT);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_CNT - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

  // Seven-segment glyph for one hex nibble, bit order g..a, active-low.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] glyph;
    case (nib)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      4'hF:    glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
    return glyph;
  endfunction

  // Filter stages and the accepted (displayed) value.
  logic [31:0]         s1_r;
  logic [31:0]         s2_r;
  logic [31:0]         shown_r;

  // Scan and dimming state.
  logic [CNT_W-1:0]    cnt_r;
  logic [2:0]          idx_r;
  logic [PWM_BITS-1:0] pwm_r;

  // Registered pin drivers.
  logic [6:0]          seg_r;
  logic                dp_r;
  logic [7:0]          an_r;

  // Combinational decisions for the digit currently selected.
  logic                tick_s;
  logic [3:0]          nibble_s;
  logic [7:0]          nz_above_s;
  logic                blank_s;
  logic                pwm_on_s;
  logic                dp_slot_s;
  logic                lit_s;

  // nz_above_s[i] is set when any nibble from digit i upward is non-zero.
  for (genvar g = 0; g < 8; g++) begin : g_nz_above
    assign nz_above_s[g] = |shown_r[31:4*g];
  end

  // Two-sample agreement filter: only a value seen on two consecutive edges
  // is accepted, so a one-cycle glitch from the other domain is dropped.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      s1_r    <= 32'd0;
      s2_r    <= 32'd0;
      shown_r <= 32'd0;
    end else begin
      s1_r <= keycodes;
      s2_r <= s1_r;
      if (s1_r == s2_r) begin
        shown_r <= s2_r;
      end else begin
        shown_r <= shown_r;
      end
    end
  end

  // Slot timer; its wrap cycle advances the digit index (7 wraps to 0).
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= 3'd0;
    end else if (tick_s) begin
      cnt_r <= '0;
      idx_r <= idx_r + 3'd1;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
      idx_r <= idx_r;
    end
  end

  // Free-running dimming counter.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      pwm_r <= '0;
    end else begin
      pwm_r <= pwm_r + PWM_ONE;
    end
  end

  // Decide whether the selected digit is lit this cycle and what it shows.
  always_comb begin
    tick_s    = 1'b0;
    nibble_s  = 4'h0;
    blank_s   = 1'b0;
    pwm_on_s  = 1'b0;
    dp_slot_s = 1'b0;
    lit_s     = 1'b0;

    tick_s   = (cnt_r == CNT_LAST);
    nibble_s = shown_r[{idx_r, 2'b00} +: 4];
    pwm_on_s = (pwm_r <= brightness);

    // Digit 0 always shows, so an all-zero value still reads "0".
    if (blank_zeros && (idx_r != 3'd0)) begin
      blank_s = ~nz_above_s[idx_r];
    end else begin
      blank_s = 1'b0;
    end

    // Decimal points on digits 2, 4 and 6 mark the byte boundaries.
    dp_slot_s = (idx_r != 3'd0) && (idx_r[0] == 1'b0);

    // The index-change cycle is dark so the old glyph never ghosts onto
    // the next anode.
    if (tick_s) begin
      lit_s = 1'b0;
    end else begin
      lit_s = ~blank_s & pwm_on_s;
    end
  end

  // Output registers: one active-low anode when lit, otherwise fully dark.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      an_r  <= 8'hFF;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else if (lit_s) begin
      an_r  <= ~(8'h01 << idx_r);
      seg_r <= hex7(nibble_s);
      dp_r  <= ~dp_slot_s;
    end else begin
      an_r  <= 8'hFF;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end
  end

  assign seg = seg_r;
  assign dp  = dp_r;
  assign an  = an_r;

endmodule

// File: tb/tb_kbd_sseg_display.sv
// Bench for kbd_sseg_display with a short slot length. A time-based
// reference model predicts every output cycle; directed phases add
// fixed-value checks for decode, blanking, dimming and reset.

module tb_kbd_sseg_display;

  localparam int R = 4;

  logic        clk_100mhz = 1'b0;
  logic        rst;
  logic [31:0] keycodes;
  logic        blank_zeros;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: edges since reset, accepted value, last samples.
  int unsigned m_t;
  logic [31:0] m_shown;
  logic [31:0] m_new;
  logic [31:0] m_old;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Expected glyph per digit 0..7 for 32'h12F01C5A (nibbles A,5,C,1,0,F,2,1).
  logic [6:0] scan_tbl [8] = '{7'h08, 7'h12, 7'h46, 7'h79, 7'h40, 7'h0E, 7'h24, 7'h79};

  kbd_sseg_display #(.REFRESH_CNT(R), .PWM_BITS(4)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .keycodes   (keycodes),
    .blank_zeros(blank_zeros),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic int m_idx();
    return int'((m_t / R) % 8);
  endfunction

  // Predict the outputs after the coming edge, advance the model, clock, compare.
  task automatic step();
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [7:0]  one_hot;
    logic [31:0] upper;
    int          idx;
    logic        blank;
    logic        lit;
    if (rst) begin
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      idx     = m_idx();
      upper   = m_shown >> (4 * idx);
      blank   = blank_zeros && (idx != 0) && (upper == 32'd0);
      lit     = ((m_t % R) != R - 1) && !blank && (int'(m_t % 16) <= int'(brightness));
      one_hot = 8'h01 << idx;
      e_an    = lit ? ~one_hot : 8'hFF;
      e_seg   = lit ? glyph[upper[3:0]] : 7'h7F;
      e_dp    = !(lit && (idx == 2 || idx == 4 || idx == 6));
    end
    if (rst) begin
      m_t     = 0;
      m_shown = 32'd0;
      m_new   = 32'd0;
      m_old   = 32'd0;
    end else begin
      if (m_new == m_old) m_shown = m_old;
      m_old = m_new;
      m_new = keycodes;
      m_t++;
    end
    @(posedge clk_100mhz);
    #1;
    check("an",  32'(an),  32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp",  32'(dp),  32'(e_dp));
  endtask

  initial begin
    int       lit_cnt;
    int       guard;
    logic [7:0] seen;
    logic [7:0] m;

    // Reset held three edges with all-ones input.
    rst         = 1'b1;
    keycodes    = 32'hFFFF_FFFF;
    blank_zeros = 1'b0;
    brightness  = 4'd15;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_an",  32'(an),  32'h0000_00FF);
      check("rst_seg", 32'(seg), 32'h0000_007F);
      check("rst_dp",  32'(dp),  32'd1);
    end
    rst = 1'b0;
    #1;
    check("rel_an", 32'(an), 32'h0000_00FF);

    // Scan and decode with a fixed pattern.
    keycodes = 32'h12F0_1C5A;
    for (int k = 0; k < 2 * 8 * R; k++) step();
    seen = 8'h00;
    for (int k = 0; k < 8 * R + 4; k++) begin
      step();
      for (int i = 0; i < 8; i++) begin
        m = 8'h01 << i;
        if (an === ~m) begin
          seen[i] = 1'b1;
          check("scan_seg", 32'(seg), 32'(scan_tbl[i]));
          check("scan_dp",  32'(dp),  (i == 2 || i == 4 || i == 6) ? 32'd0 : 32'd1);
        end
      end
    end
    check("scan_all_digits", 32'(seen), 32'h0000_00FF);

    // Leading-zero blanking.
    blank_zeros = 1'b1;
    keycodes    = 32'h0000_00F0;
    for (int k = 0; k < 4; k++) step();
    for (int k = 0; k < 8 * R + 4; k++) begin
      step();
      if (an !== 8'hFF) begin
        check("blk_digit", 32'((an === 8'hFE) || (an === 8'hFD)), 32'd1);
        check("blk_seg", 32'(seg), (an === 8'hFE) ? 32'h40 : 32'h0E);
        check("blk_dp",  32'(dp),  32'd1);
      end
    end
    keycodes = 32'h0000_0000;
    for (int k = 0; k < 4; k++) step();
    for (int k = 0; k < 8 * R + 4; k++) begin
      step();
      if (an !== 8'hFF) begin
        check("zero_an",  32'(an),  32'h0000_00FE);
        check("zero_seg", 32'(seg), 32'h0000_0040);
      end
    end

    // One-cycle glitch must never be accepted.
    blank_zeros = 1'b0;
    keycodes    = 32'hAAAA_AAAA;
    step();
    keycodes    = 32'h0000_0000;
    for (int k = 0; k < 8 * R + 4; k++) begin
      step();
      if (an !== 8'hFF) check("glitch_seg", 32'(seg), 32'h0000_0040);
    end
    // A held change is accepted three edges later (model-checked).
    keycodes = 32'hAAAA_AAAA;
    for (int k = 0; k < 8 * R; k++) step();

    // Dimming: brightness 0 lights one cycle in sixteen.
    brightness = 4'd0;
    lit_cnt    = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an !== 8'hFF) lit_cnt++;
    end
    check("br0_duty", 32'(lit_cnt), 32'd1);
    brightness = 4'd7;
    for (int k = 0; k < 32; k++) step();
    brightness = 4'd15;
    for (int k = 0; k < 32; k++) step();

    // Randomized inputs, including short-lived changes.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) keycodes = $urandom;
      if ($urandom_range(0, 5) == 0) keycodes = keycodes & ($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 30) == 0) blank_zeros = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 30) == 0) brightness  = 4'($urandom_range(0, 15));
      step();
    end

    // Reset in the middle of the digit-5 slot.
    brightness  = 4'd15;
    blank_zeros = 1'b0;
    keycodes    = 32'h8765_4321;
    guard       = 0;
    while (m_idx() != 5 && guard < 200) begin
      step();
      guard++;
    end
    check("reach_idx5", 32'(guard < 200), 32'd1);
    step();
    rst = 1'b1;
    step();
    check("midrst_an", 32'(an), 32'h0000_00FF);
    rst = 1'b0;
    for (int k = 0; k < R; k++) begin
      step();
      check("restart_an", 32'(an), (k == R - 1) ? 32'h0000_00FF : 32'h0000_00FE);
    end
    for (int k = 0; k < 8 * R; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
